// File: rtl/sign_mag_alu_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sign_mag_alu_acc                                              |
// | Purpose  : Registered sign-magnitude add/subtract unit with a running    |
// |            accumulator and valid/ready handshakes on both sides.         |
// |            Operands and results are N-bit sign-magnitude: the MSB is     |
// |            the sign (1 = negative) and the low N-1 bits are the          |
// |            magnitude.                                                    |
// | Ports    : clk        rising-edge clock                                  |
// |            rst_n      asynchronous active-low reset                      |
// |            in_valid   operand/op presented                               |
// |            in_ready   block can accept this cycle                        |
// |            op         00 A+B, 01 A-B, 10 acc+=A, 11 clear acc            |
// |            A, B       sign-magnitude operands (B unused for op 10/11)    |
// |            out_valid  Sum/ovf hold a result                              |
// |            out_ready  consumer takes the result                          |
// |            Sum        registered result, never negative zero            |
// |            ovf        magnitude overflow on this result                  |
// |            acc        current accumulator value (registered)            |
// | Options  : SIGN_MAG_SATURATE_EN - when defined, an overflowing result    |
// |            saturates to the largest magnitude with its sign kept.        |
// |            When undefined, the magnitude wraps to the low N-1 bits of    |
// |            the true sum.                                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sign_mag_alu_acc #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         ovf,
  output logic [N-1:0] acc
);

  // Magnitude width
  localparam int M = N - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic         accept;

  // Normalised operand fields (negative zero folded to +0)
  logic [M-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic [M-1:0] acc_mag;
  logic         a_sgn;
  logic         b_sgn;
  logic         b_sgn_inv;
  logic         acc_sgn;

  // Selected operand pair
  logic         x_sgn;
  logic [M-1:0] x_mag;
  logic         y_sgn;
  logic [M-1:0] y_mag;

  // Arithmetic
  logic [M:0]   mag_sum;
  logic         x_ge_y;
  logic         res_sgn;
  logic [M-1:0] res_mag;
  logic         res_ovf;
  logic [N-1:0] res;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_mag     = A[M-1:0];
    b_mag     = B[M-1:0];
    acc_mag   = acc[M-1:0];
    a_sgn     = A[N-1] & (|a_mag);
    b_sgn     = B[N-1] & (|b_mag);
    // Inverting B's sign must not turn +0 into -0
    b_sgn_inv = ~B[N-1] & (|b_mag);
    acc_sgn   = acc[N-1] & (|acc_mag);
  end

  always_comb begin
    x_sgn = 1'b0;
    x_mag = '0;
    y_sgn = 1'b0;
    y_mag = '0;
    case (op)
      OP_ADD: begin
        x_sgn = a_sgn;
        x_mag = a_mag;
        y_sgn = b_sgn;
        y_mag = b_mag;
      end
      OP_SUB: begin
        x_sgn = a_sgn;
        x_mag = a_mag;
        y_sgn = b_sgn_inv;
        y_mag = b_mag;
      end
      OP_ACC: begin
        x_sgn = acc_sgn;
        x_mag = acc_mag;
        y_sgn = a_sgn;
        y_mag = a_mag;
      end
      default: begin
        // Clear: operands stay zero, result is +0
      end
    endcase
  end

  always_comb begin
    mag_sum = {1'b0, x_mag} + {1'b0, y_mag};
    x_ge_y  = (x_mag >= y_mag);
    res_sgn = 1'b0;
    res_mag = '0;
    res_ovf = 1'b0;

    if (x_sgn == y_sgn) begin
      // Like signs: add magnitudes, carry out of the magnitude is overflow
      res_sgn = x_sgn;
      res_ovf = mag_sum[M];
`ifdef SIGN_MAG_SATURATE_EN
      res_mag = mag_sum[M] ? {M{1'b1}} : mag_sum[M-1:0];
`else
      res_mag = mag_sum[M-1:0];
`endif
    end else if (x_ge_y) begin
      res_sgn = x_sgn;
      res_mag = x_mag - y_mag;
    end else begin
      res_sgn = y_sgn;
      res_mag = y_mag - x_mag;
    end

    if (op == OP_CLR) begin
      res_sgn = 1'b0;
      res_mag = '0;
      res_ovf = 1'b0;
    end

    // A zero magnitude (including a wrapped overflow) is always +0
    res = {res_sgn & (|res_mag), res_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      // Covers both a fresh accept and a same-edge transfer + accept
      out_valid <= 1'b1;
      Sum       <= res;
      ovf       <= res_ovf;
      if (op == OP_ACC) begin
        acc <= res;
      end else if (op == OP_CLR) begin
        acc <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sign_mag_alu_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sign_mag_alu_acc                                           |
// | Purpose  : Self-checking bench for sign_mag_alu_acc (N = 5). Directed    |
// |            vector table plus hand-written backpressure and async-reset   |
// |            sequences. Expected values follow SIGN_MAG_SATURATE_EN.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sign_mag_alu_acc;

  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         ovf;
  logic [N-1:0] acc;

  int errors = 0;
  int checks = 0;

  sign_mag_alu_acc #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .ovf       (ovf),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         ovf;
    logic [N-1:0] acc;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = v;
    op       = o;
    A        = a;
    B        = b;
  endtask

  initial begin
`ifdef SIGN_MAG_SATURATE_EN
    vecs[0]  = '{2'b00, 5'b10001, 5'b10001, 5'b10010, 1'b0, 5'b00000};
    vecs[1]  = '{2'b00, 5'b10011, 5'b00001, 5'b10010, 1'b0, 5'b00000};
    vecs[2]  = '{2'b01, 5'b00101, 5'b00101, 5'b00000, 1'b0, 5'b00000};
    vecs[3]  = '{2'b00, 5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b00000};
    vecs[4]  = '{2'b00, 5'b01111, 5'b00001, 5'b01111, 1'b1, 5'b00000};
    vecs[5]  = '{2'b00, 5'b11111, 5'b10001, 5'b11111, 1'b1, 5'b00000};
    vecs[6]  = '{2'b01, 5'b00011, 5'b10100, 5'b00111, 1'b0, 5'b00000};
    vecs[7]  = '{2'b01, 5'b10010, 5'b00111, 5'b11001, 1'b0, 5'b00000};
    vecs[8]  = '{2'b00, 5'b00010, 5'b10111, 5'b10101, 1'b0, 5'b00000};
    vecs[9]  = '{2'b01, 5'b10000, 5'b10000, 5'b00000, 1'b0, 5'b00000};
    vecs[10] = '{2'b11, 5'b01111, 5'b01111, 5'b00000, 1'b0, 5'b00000};
    vecs[11] = '{2'b10, 5'b00011, 5'b11111, 5'b00011, 1'b0, 5'b00011};
    vecs[12] = '{2'b10, 5'b10101, 5'b00000, 5'b10010, 1'b0, 5'b10010};
    vecs[13] = '{2'b10, 5'b00001, 5'b00000, 5'b10001, 1'b0, 5'b10001};
    vecs[14] = '{2'b00, 5'b01010, 5'b00011, 5'b01101, 1'b0, 5'b10001};
    vecs[15] = '{2'b10, 5'b11111, 5'b00000, 5'b11111, 1'b1, 5'b11111};
    vecs[16] = '{2'b10, 5'b01000, 5'b00000, 5'b10111, 1'b0, 5'b10111};
    vecs[17] = '{2'b11, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000};
`else
    vecs[0]  = '{2'b00, 5'b10001, 5'b10001, 5'b10010, 1'b0, 5'b00000};
    vecs[1]  = '{2'b00, 5'b10011, 5'b00001, 5'b10010, 1'b0, 5'b00000};
    vecs[2]  = '{2'b01, 5'b00101, 5'b00101, 5'b00000, 1'b0, 5'b00000};
    vecs[3]  = '{2'b00, 5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b00000};
    vecs[4]  = '{2'b00, 5'b01111, 5'b00001, 5'b00000, 1'b1, 5'b00000};
    vecs[5]  = '{2'b00, 5'b11111, 5'b10001, 5'b00000, 1'b1, 5'b00000};
    vecs[6]  = '{2'b01, 5'b00011, 5'b10100, 5'b00111, 1'b0, 5'b00000};
    vecs[7]  = '{2'b01, 5'b10010, 5'b00111, 5'b11001, 1'b0, 5'b00000};
    vecs[8]  = '{2'b00, 5'b00010, 5'b10111, 5'b10101, 1'b0, 5'b00000};
    vecs[9]  = '{2'b01, 5'b10000, 5'b10000, 5'b00000, 1'b0, 5'b00000};
    vecs[10] = '{2'b11, 5'b01111, 5'b01111, 5'b00000, 1'b0, 5'b00000};
    vecs[11] = '{2'b10, 5'b00011, 5'b11111, 5'b00011, 1'b0, 5'b00011};
    vecs[12] = '{2'b10, 5'b10101, 5'b00000, 5'b10010, 1'b0, 5'b10010};
    vecs[13] = '{2'b10, 5'b00001, 5'b00000, 5'b10001, 1'b0, 5'b10001};
    vecs[14] = '{2'b00, 5'b01010, 5'b00011, 5'b01101, 1'b0, 5'b10001};
    vecs[15] = '{2'b10, 5'b11111, 5'b00000, 5'b00000, 1'b1, 5'b00000};
    vecs[16] = '{2'b10, 5'b01000, 5'b00000, 5'b01000, 1'b0, 5'b01000};
    vecs[17] = '{2'b11, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000};
`endif

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, '0, '0);
    #1;
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", Sum, 0);
    check("reset_ovf", ovf, 0);
    check("reset_acc", acc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back vectors with the consumer always ready
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_sum", i), Sum, vecs[i].sum);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      check($sformatf("vec%0d_acc", i), acc, vecs[i].acc);
    end

    // Idle with consumer ready: out_valid drops, Sum holds
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    @(posedge clk);
    #1;
    check("drain_valid", out_valid, 0);
    check("drain_sum_hold", Sum, 0);

    // Backpressure: pending 00011, stall 3 cycles with in_valid high
    @(negedge clk);
    drive(1'b1, 2'b00, 5'b00001, 5'b00010);
    @(posedge clk);
    #1;
    check("bp_first_sum", Sum, 5'b00011);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 5'b00101, 5'b00000);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_in_ready", c), in_ready, 0);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", c), out_valid, 1);
      check($sformatf("bp%0d_sum", c), Sum, 5'b00011);
      check($sformatf("bp%0d_acc", c), acc, 5'b00000);
      @(negedge clk);
    end
    // Release: transfer and accept on the same edge
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 1);
    check("bp_release_sum", Sum, 5'b00101);
    check("bp_release_acc", acc, 5'b00101);
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);
    @(posedge clk);
    #1;
    check("bp_drain_valid", out_valid, 0);
    check("bp_drain_sum", Sum, 5'b00101);

    // Asynchronous reset with a pending result and acc = -1
    @(negedge clk);
    drive(1'b1, 2'b11, '0, '0);
    @(negedge clk);
    drive(1'b1, 2'b10, 5'b10001, '0);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_acc", acc, 5'b10001);
    check("pre_rst_sum", Sum, 5'b10001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", Sum, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_acc", acc, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 2'b00, 5'b00001, 5'b00001);
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_sum", Sum, 5'b00010);
    @(negedge clk);
    drive(1'b0, 2'b00, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sign_mag_alu_acc.md
Name: sign_mag_alu_acc

Overview:
- Parametrised, registered sign-magnitude add/subtract unit with a running accumulator; successor to the combinational sign-magnitude adder.
- Operands are N-bit sign-magnitude: MSB = sign (1 = negative), low N-1 bits = magnitude.
- Valid/ready handshake on input and output; one result register; overflow flag.
- Sits between operand sources and any sign-magnitude consumer that can apply backpressure.

Parameters:
- N, 5, total operand/result width including sign bit (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  block can accept this cycle
- op  input  2  00 A+B, 01 A-B, 10 ACC+=A, 11 clear ACC
- A  input  N  operand A, sign-magnitude
- B  input  N  operand B, sign-magnitude; ignored for op 10/11
- out_valid  output  1  Sum/ovf hold a result
- out_ready  input  1  consumer takes result
- Sum  output  N  registered result, sign-magnitude
- ovf  output  1  magnitude overflow on this result
- acc  output  N  current accumulator value (registered)

Behaviour:
- Reset (rst_n low, asynchronous, any time incl. mid-transfer): out_valid=0, Sum=0, ovf=0, acc=0; in_ready follows its equation (1 during reset). Pending result is discarded.
- Handshake: in_ready = !out_valid || out_ready. Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Latency: 1 cycle. Result of an accept at edge k is on Sum/ovf with out_valid=1 after edge k.
- Simultaneous output transfer and new accept: Sum/ovf replaced by new result; out_valid stays 1.
- No accept and output transferred: out_valid -> 0; Sum/ovf hold their last values.
- out_valid=1 with out_ready=0: Sum, ovf, acc stable; in_ready=0; inputs ignored.
- Operand pair X,Y per op: 00 X=A,Y=B; 01 X=A,Y=B with sign inverted; 10 X=acc,Y=A; 11 no arithmetic, result +0.
- Negative zero on any input (sign 1, magnitude 0) is treated as +0.
- Signs equal: magnitude = |X|+|Y| on N bits; carry out of bit N-2 -> overflow; sign = common sign.
- Signs differ: larger magnitude minus smaller; sign of the larger; equal magnitudes -> +0.
- Output never -0. A result with magnitude 0 gets sign 0, including a wrapped overflow result.
- ovf=1 only when the overflow condition holds; 0 otherwise, and 0 for op 11.
- Accumulator: on accept with op 10, acc <= result (same value as Sum, including overflow handling). On accept with op 11, acc <= 0 and Sum <= 0. Ops 00/01 leave acc unchanged.
- acc updates on the accept edge, same edge as Sum.

Optional Feature:
- Macro SIGN_MAG_SATURATE_EN.
- Defined: on overflow, magnitude = all ones (2^(N-1)-1), sign kept, ovf=1. The accumulator saturates the same way.
- Undefined: on overflow, magnitude = low N-1 bits of the true sum (wrap), sign kept unless magnitude 0, ovf=1.

Test Plan:
- N=5, op=00, A=10001, B=10001 -> one cycle later out_valid=1, Sum=10010, ovf=0.
- op=00, A=10011, B=00001 -> Sum=10010. Then op=01, A=00101, B=00101 -> Sum=00000. Then op=00, A=10000, B=00000 -> Sum=00000 (never 10000).
- op=00, A=01111, B=00001 -> ovf=1; Sum=00000 without macro, Sum=01111 with SIGN_MAG_SATURATE_EN. Also A=11111, B=10001 -> ovf=1; Sum=10000 without macro is not allowed, Sum=00000; Sum=11111 with macro.
- Backpressure: result pending, hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, Sum and acc stable, no accept. Assert out_ready with in_valid=1 -> transfer and new accept on the same edge, out_valid stays 1.
- Accumulate: op 11, then op 10 with A=00011, A=10101, A=00001 -> acc/Sum = 00000, 00011, 10010, 10001 on successive results.
- Drop rst_n asynchronously between clock edges while out_valid=1 and acc=10001 -> out_valid, Sum, ovf and acc go to 0 immediately without waiting for a clock. First accept after release -> result on the next edge.
